axi_graphics_frame_ctrl: RTL
============================

Name: axi_graphics_frame_ctrl

Overview:
- Frame sequencer that feeds the AXIS video output of axi_graphics from a generic pixel source (pattern generator or framebuffer reader).
- Counts pixels and lines, emits tuser on the first pixel of each frame and tlast on the last pixel of each line.
- Runs single-shot or continuous frames and reports status back to the AXI-lite register block.

Parameters:
- AXIS_DATA_WIDTH, 32, pixel/tdata width.
- DIM_WIDTH, 16, width of the frame width/height and coordinate fields.
- FCOUNT_WIDTH, 32, width of the frame counter.

Ports:
- i_axi_clk  in  1  sole clock.
- i_axi_rst  in  1  asynchronous, active-low reset.
- i_enable  in  1  level; frames may start while high.
- i_continuous  in  1  1 = back-to-back frames; 0 = one frame per i_start.
- i_start  in  1  single-cycle pulse; starts a frame when IDLE and i_enable=1.
- i_width  in  DIM_WIDTH  pixels per line; latched at frame start.
- i_height  in  DIM_WIDTH  lines per frame; latched at frame start.
- o_busy  out  1  high in ACTIVE or DRAIN.
- o_frame_done  out  1  single-cycle pulse when the last pixel of a frame is accepted downstream.
- o_frame_count  out  FCOUNT_WIDTH  completed frames; wraps.
- o_cfg_error  out  1  sticky; set on a start attempt with zero width or height; cleared by i_start with valid dims.
- o_pix_x  out  DIM_WIDTH  column of the pixel being requested.
- o_pix_y  out  DIM_WIDTH  line of the pixel being requested.
- i_pix_valid  in  1  source data valid.
- o_pix_ready  out  1  source handshake; transfer when valid and ready.
- i_pix_data  in  AXIS_DATA_WIDTH  pixel value for (o_pix_x, o_pix_y).
- o_axis_out_tuser  out  1  start of frame.
- o_axis_out_tvalid  out  1  AXIS valid.
- i_axis_out_tready  in  1  AXIS ready.
- o_axis_out_tlast  out  1  end of line.
- o_axis_out_tdata  out  AXIS_DATA_WIDTH  pixel.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including counters, coordinates and o_cfg_error.
- IDLE:
  - Transition to ACTIVE on i_enable and (i_start or i_continuous), provided latched dims are nonzero.
  - On the same edge: latch width/height; x=y=0.
  - With zero dims, stay IDLE and set o_cfg_error.
- ACTIVE:
  - o_pix_ready = !out_valid | i_axis_out_tready (single output register; full-throughput skid-free slice).
  - On a source transfer:
    - Load the out register: tdata=i_pix_data; tuser=(x==0 && y==0); tlast=(x==width-1).
    - Advance x; at x==width-1, x←0 and y++.
    - When the transfer is pixel (width-1, height-1), go to DRAIN.
- DRAIN:
  - o_pix_ready=0; wait for the last beat to be accepted (tvalid & tready).
  - On that beat: pulse o_frame_done; o_frame_count++.
  - Then go ACTIVE (new latch, x=y=0) if i_enable && i_continuous; else go IDLE.
  - A frame may restart in the acceptance cycle, so continuous mode has a 1-cycle bubble maximum between frames.
- Output register:
  - tvalid is held with data stable until tready.
  - The register is cleared (tvalid←0) when accepted and no new transfer occurs.
  - AXIS rules: no tvalid deassertion without acceptance.
- Source underflow: i_pix_valid low → no output beat; no filler pixels; counters hold.
- i_enable low mid-frame: the current frame completes; no new frame starts.
- i_start while busy: ignored.
- Config changes mid-frame: ignored until the next latch.
- width=1: every beat has tlast=1. height=1: a single line.
- o_pix_x/o_pix_y are valid whenever ACTIVE and reflect the next pixel to be transferred.
- Latency: source transfer → tvalid at the next cycle (1 cycle).

Decomposition:
- Shared package axi_graphics_pkg:
  - state encoding localparams (IDLE=0, ACTIVE=1, DRAIN=2);
  - DIM_WIDTH default;
  - tuser/tlast bit positions used by the register block status read.
- One natural sub-module: axi_graphics_axis_reg (single-stage valid/ready output register carrying tdata/tuser/tlast). The counters and FSM stay in the top.

Test Plan:
- width=4, height=3, single-shot, source always valid, tready=1 → 12 beats on consecutive cycles; tuser only on beat 0; tlast on beats 3, 7, 11; one o_frame_done after beat 11; o_frame_count=1; returns to IDLE.
- Same frame with tready toggling 1010… and i_pix_valid random → identical 12-beat data/tuser/tlast sequence; tdata stable while tvalid && !tready; no dropped or duplicated pixels (pixel = y*256+x checked).
- Continuous mode, width=2, height=2, 3 frames → o_frame_count=3; at most 1 idle cycle between frames; then drop i_enable during frame 4 → frame 4 completes (4 beats) and the block idles with count=4.
- i_start with width=0, height=5 → no beats; o_cfg_error=1, o_busy=0; then i_start with 1×1 → single beat with tuser=tlast=1; o_cfg_error cleared.
- Change i_width from 4 to 8 mid-frame → current frame keeps tlast every 4 beats; the next continuous frame uses 8.
- Assert reset mid-frame with tvalid high → all outputs 0 immediately (async); after release, state IDLE and o_frame_count=0.

Source files
------------

// File: rtl/axi_graphics_pkg.sv
// ---------------------------------------------------------------------------
// axi_graphics_pkg
// Shared definitions for the axi_graphics video output path: frame sequencer
// state encoding, default coordinate width and the bit positions the AXI-lite
// register block uses when it reports the live tuser/tlast flags.
// ---------------------------------------------------------------------------
package axi_graphics_pkg;

  // Frame sequencer state encoding (kept as plain constants so the register
  // block can expose the raw state value on a status read).
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  // Default width of frame dimensions and pixel coordinates.
  localparam int DIM_WIDTH_DEF = 16;

  // Status word bit positions for the output beat flags.
  localparam int STATUS_TUSER_BIT = 0;
  localparam int STATUS_TLAST_BIT = 1;

  // True when both frame dimensions can describe a real frame.
  function automatic logic dims_valid(input logic [DIM_WIDTH_DEF-1:0] w,
                                      input logic [DIM_WIDTH_DEF-1:0] h);
    return (w != '0) && (h != '0);
  endfunction

endpackage

// File: rtl/axi_graphics_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// axi_graphics_frame_ctrl_if
// Bundles the pixel-source handshake and the AXIS video output of the frame
// sequencer.
//   pix_x/pix_y        coordinate of the pixel being requested
//   pix_valid/ready    source handshake, pix_data is the pixel at (x, y)
//   axis_out_*         AXI4-Stream video output (tuser = SOF, tlast = EOL)
// Modports: master = frame sequencer side, slave = source + downstream sink.
// ---------------------------------------------------------------------------
interface axi_graphics_frame_ctrl_if #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int DIM_WIDTH       = 16
);
  logic [DIM_WIDTH-1:0]       pix_x;
  logic [DIM_WIDTH-1:0]       pix_y;
  logic                       pix_valid;
  logic                       pix_ready;
  logic [AXIS_DATA_WIDTH-1:0] pix_data;
  logic                       axis_out_tuser;
  logic                       axis_out_tvalid;
  logic                       axis_out_tready;
  logic                       axis_out_tlast;
  logic [AXIS_DATA_WIDTH-1:0] axis_out_tdata;

  modport master (
    output pix_x, pix_y, pix_ready,
    output axis_out_tuser, axis_out_tvalid, axis_out_tlast, axis_out_tdata,
    input  pix_valid, pix_data, axis_out_tready
  );

  modport slave (
    input  pix_x, pix_y, pix_ready,
    input  axis_out_tuser, axis_out_tvalid, axis_out_tlast, axis_out_tdata,
    output pix_valid, pix_data, axis_out_tready
  );
endinterface

// File: rtl/axi_graphics_axis_reg.sv
// ---------------------------------------------------------------------------
// axi_graphics_axis_reg
// Single-stage AXIS output register carrying tdata/tuser/tlast.
//   clk_i, rst_ni        clock, async active-low reset
//   load_i               capture a new beat (only asserted while ready_o)
//   tdata_i/tuser_i/tlast_i  beat contents to capture
//   tready_i             downstream ready
//   ready_o              slot free or draining this cycle
//   tvalid_o/tdata_o/tuser_o/tlast_o  registered beat
// ---------------------------------------------------------------------------
module axi_graphics_axis_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] tdata_i,
  input  logic                  tuser_i,
  input  logic                  tlast_i,
  input  logic                  tready_i,
  output logic                  ready_o,
  output logic                  tvalid_o,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tuser_o,
  output logic                  tlast_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  user_q, user_d;
  logic                  last_q, last_d;

  // Accepting a new beat in the same cycle the old one leaves keeps full
  // throughput without a skid buffer; the beat is otherwise held stable.
  assign ready_o = !valid_q || tready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    user_d  = user_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = tdata_i;
      user_d  = tuser_i;
      last_d  = tlast_i;
    end else if (tready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      user_q  <= user_d;
      last_q  <= last_d;
    end
  end

  assign tvalid_o = valid_q;
  assign tdata_o  = data_q;
  assign tuser_o  = user_q;
  assign tlast_o  = last_q;

endmodule

// File: rtl/axi_graphics_frame_ctrl.sv
// ---------------------------------------------------------------------------
// axi_graphics_frame_ctrl
// Frame sequencer feeding the axi_graphics AXIS video output from a generic
// pixel source. Walks (x, y) over a latched width x height frame, marks the
// first pixel with tuser and each line end with tlast, and reports status.
//   i_axi_clk, i_axi_rst   clock, async active-low reset
//   i_enable, i_continuous, i_start   frame start control
//   i_width, i_height      frame geometry, latched at each frame start
//   o_busy, o_frame_done, o_frame_count, o_cfg_error   status
//   bus                    pixel source handshake + AXIS output (master)
// ---------------------------------------------------------------------------
module axi_graphics_frame_ctrl
  import axi_graphics_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int DIM_WIDTH       = DIM_WIDTH_DEF,
  parameter int FCOUNT_WIDTH    = 32
) (
  input  logic                    i_axi_clk,
  input  logic                    i_axi_rst,
  input  logic                    i_enable,
  input  logic                    i_continuous,
  input  logic                    i_start,
  input  logic [DIM_WIDTH-1:0]    i_width,
  input  logic [DIM_WIDTH-1:0]    i_height,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic [FCOUNT_WIDTH-1:0] o_frame_count,
  output logic                    o_cfg_error,
  axi_graphics_frame_ctrl_if.master bus
);

  logic [1:0]              state_q, state_d;
  logic [DIM_WIDTH-1:0]    width_q, width_d;
  logic [DIM_WIDTH-1:0]    height_q, height_d;
  logic [DIM_WIDTH-1:0]    x_q, x_d;
  logic [DIM_WIDTH-1:0]    y_q, y_d;
  logic [FCOUNT_WIDTH-1:0] count_q, count_d;
  logic                    done_q, done_d;
  logic                    cfg_err_q, cfg_err_d;

  logic dims_ok;
  logic slot_ready;
  logic pix_ready;
  logic xfer;
  logic last_x;
  logic last_y;
  logic out_accept;

  assign dims_ok    = (i_width != '0) && (i_height != '0);
  assign pix_ready  = (state_q == ST_ACTIVE) && slot_ready;
  assign xfer       = pix_ready && bus.pix_valid;
  assign last_x     = (x_q == width_q - DIM_WIDTH'(1));
  assign last_y     = (y_q == height_q - DIM_WIDTH'(1));
  assign out_accept = bus.axis_out_tvalid && bus.axis_out_tready;

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    x_d       = x_q;
    y_d       = y_q;
    count_d   = count_q;
    done_d    = 1'b0;
    cfg_err_d = cfg_err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable && (i_start || i_continuous)) begin
          if (dims_ok) begin
            state_d  = ST_ACTIVE;
            width_d  = i_width;
            height_d = i_height;
            x_d      = '0;
            y_d      = '0;
            if (i_start) cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (xfer) begin
          if (last_x) begin
            x_d = '0;
            if (last_y) begin
              y_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              y_d = y_q + DIM_WIDTH'(1);
            end
          end else begin
            x_d = x_q + DIM_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Restarting in the acceptance cycle limits the inter-frame gap to
        // one bubble in continuous mode.
        if (out_accept) begin
          done_d  = 1'b1;
          count_d = count_q + FCOUNT_WIDTH'(1);
          if (i_enable && i_continuous && dims_ok) begin
            state_d  = ST_ACTIVE;
            width_d  = i_width;
            height_d = i_height;
            x_d      = '0;
            y_d      = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      state_q   <= ST_IDLE;
      width_q   <= '0;
      height_q  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      height_q  <= height_d;
      x_q       <= x_d;
      y_q       <= y_d;
      count_q   <= count_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  axi_graphics_axis_reg #(
    .DATA_WIDTH(AXIS_DATA_WIDTH)
  ) u_out_reg (
    .clk_i    (i_axi_clk),
    .rst_ni   (i_axi_rst),
    .load_i   (xfer),
    .tdata_i  (bus.pix_data),
    .tuser_i  ((x_q == '0) && (y_q == '0)),
    .tlast_i  (last_x),
    .tready_i (bus.axis_out_tready),
    .ready_o  (slot_ready),
    .tvalid_o (bus.axis_out_tvalid),
    .tdata_o  (bus.axis_out_tdata),
    .tuser_o  (bus.axis_out_tuser),
    .tlast_o  (bus.axis_out_tlast)
  );

  assign bus.pix_x     = x_q;
  assign bus.pix_y     = y_q;
  assign bus.pix_ready = pix_ready;

  assign o_busy        = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);
  assign o_frame_done  = done_q;
  assign o_frame_count = count_q;
  assign o_cfg_error   = cfg_err_q;

endmodule
